// File: rtl/hdmi_text_grid_if.sv
// Purpose: bundles the timing-in, scroll/cursor configuration and cell-coordinate outputs of the text grid mapper.
// Latency: n/a (wires only).
// Backpressure: none; this is a free-running video stream with no flow control.
interface hdmi_text_grid_if #(
    parameter int CELL_W = 10,
    parameter int CELL_H = 20,
    parameter int COLS   = 80,
    parameter int ROWS   = 30
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int PW = $clog2(CELL_W);
    localparam int LW = $clog2(CELL_H);

    // timing stream from the HDMI timing generator
    logic          in_active;
    logic          in_h_sync;
    logic          in_v_sync;
    logic          in_h_start;
    logic          in_v_start;

    // frame-latched scroll/mode configuration and cursor position
    logic [RW-1:0] top_row;
    logic [LW-1:0] fine_scroll;
    logic          double_height;
    logic          cursor_enable;
    logic [RW-1:0] cursor_row;
    logic [CW-1:0] cursor_col;

    // cell coordinates towards the glyph/attribute fetch
    logic          out_active;
    logic          out_h_sync;
    logic          out_v_sync;
    logic [RW-1:0] out_row;
    logic [LW-1:0] out_row_pixel;
    logic [CW-1:0] out_col;
    logic          out_col_valid;
    logic          out_col_start;
    logic [PW-1:0] out_col_pixel;
    logic          out_cursor;
    logic          out_blink;
    logic          out_frame_start;

    modport master (
        output in_active, in_h_sync, in_v_sync, in_h_start, in_v_start,
        output top_row, fine_scroll, double_height,
        output cursor_enable, cursor_row, cursor_col,
        input  out_active, out_h_sync, out_v_sync, out_row, out_row_pixel,
        input  out_col, out_col_valid, out_col_start, out_col_pixel,
        input  out_cursor, out_blink, out_frame_start
    );

    modport slave (
        input  in_active, in_h_sync, in_v_sync, in_h_start, in_v_start,
        input  top_row, fine_scroll, double_height,
        input  cursor_enable, cursor_row, cursor_col,
        output out_active, out_h_sync, out_v_sync, out_row, out_row_pixel,
        output out_col, out_col_valid, out_col_start, out_col_pixel,
        output out_cursor, out_blink, out_frame_start
    );
endinterface

// File: rtl/hdmi_text_grid.sv
// Purpose: maps the raster timing stream to text-cell row/column/pixel coordinates with scroll, double height and cursor blink.
// Latency: 1 cycle, every output registered.
// Backpressure: none; follows the pixel clock unconditionally.
module hdmi_text_grid #(
    parameter int CELL_W       = 10,
    parameter int CELL_H       = 20,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    hdmi_text_grid_if.slave   bus
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int PW = $clog2(CELL_W);
    localparam int LW = $clog2(CELL_H);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PIX_LAST  = PW'(CELL_W - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(CELL_H - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX   = {CW{1'b1}};
    localparam logic [CW:0]   COLS_EXT  = (CW + 1)'(COLS);
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

    logic          active_q, hs_q, vs_q;
    logic [RW-1:0] row_q, row_nxt;
    logic [LW-1:0] rpix_q, rpix_nxt;
    logic          toggle_q, toggle_nxt;
    logic          dh_q, dh_nxt;
    logic [CW-1:0] col_q, col_nxt;
    logic [PW-1:0] cpix_q, cpix_nxt;
    logic          cstart_q, cstart_nxt;
    logic          cvld_q, cvld_nxt;
    logic [FW-1:0] fcnt_q, fcnt_nxt;
    logic          blink_q, blink_nxt;
    logic          cursor_q, cursor_nxt;
    logic          fstart_q;

    logic frame_start;
    logic line_start;

    // in_v_start only counts together with in_h_start on an active pixel
    assign frame_start = bus.in_active & bus.in_h_start & bus.in_v_start;
    assign line_start  = bus.in_active & bus.in_h_start & ~bus.in_v_start;

    // row tracking: reload at frame start, step one glyph line per (possibly doubled) scanline
    always_comb begin
        row_nxt    = row_q;
        rpix_nxt   = rpix_q;
        toggle_nxt = toggle_q;
        dh_nxt     = dh_q;
        if (frame_start) begin
            row_nxt    = bus.top_row;
            rpix_nxt   = (bus.fine_scroll > LINE_LAST) ? LINE_LAST : bus.fine_scroll;
            dh_nxt     = bus.double_height;
            toggle_nxt = 1'b0;
        end else if (line_start) begin
            if (!dh_q || toggle_q) begin
                if (rpix_q == LINE_LAST) begin
                    rpix_nxt = '0;
                    row_nxt  = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                end else begin
                    rpix_nxt = rpix_q + LW'(1);
                end
            end
            if (dh_q) begin
                toggle_nxt = ~toggle_q;
            end
        end
    end

    // column tracking; a new line start overrides the cell wrap, blanking clears everything
    always_comb begin
        col_nxt    = '0;
        cpix_nxt   = '0;
        cstart_nxt = 1'b0;
        if (bus.in_active) begin
            if (bus.in_h_start) begin
                cstart_nxt = 1'b1;
            end else if (cpix_q == PIX_LAST) begin
                cstart_nxt = 1'b1;
                col_nxt    = (col_q == COL_MAX) ? col_q : col_q + CW'(1);
            end else begin
                cpix_nxt = cpix_q + PW'(1);
                col_nxt  = col_q;
            end
        end
        cvld_nxt = bus.in_active & ({1'b0, col_nxt} < COLS_EXT);
    end

    // blink phase advances on frame starts; cursor uses the same-cycle row/col/blink values
    always_comb begin
        fcnt_nxt  = fcnt_q;
        blink_nxt = blink_q;
        if (frame_start) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_nxt  = '0;
                blink_nxt = ~blink_q;
            end else begin
                fcnt_nxt = fcnt_q + FW'(1);
            end
        end
        cursor_nxt = bus.cursor_enable & blink_nxt & (row_nxt == bus.cursor_row) &
                     (col_nxt == bus.cursor_col) & cvld_nxt;
    end

    // output and state registers, blink comes out of reset in the "on" phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            row_q    <= '0;
            rpix_q   <= '0;
            toggle_q <= 1'b0;
            dh_q     <= 1'b0;
            col_q    <= '0;
            cpix_q   <= '0;
            cstart_q <= 1'b0;
            cvld_q   <= 1'b0;
            fcnt_q   <= '0;
            blink_q  <= 1'b1;
            cursor_q <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            active_q <= bus.in_active;
            hs_q     <= bus.in_h_sync;
            vs_q     <= bus.in_v_sync;
            row_q    <= row_nxt;
            rpix_q   <= rpix_nxt;
            toggle_q <= toggle_nxt;
            dh_q     <= dh_nxt;
            col_q    <= col_nxt;
            cpix_q   <= cpix_nxt;
            cstart_q <= cstart_nxt;
            cvld_q   <= cvld_nxt;
            fcnt_q   <= fcnt_nxt;
            blink_q  <= blink_nxt;
            cursor_q <= cursor_nxt;
            fstart_q <= frame_start;
        end
    end

    assign bus.out_active      = active_q;
    assign bus.out_h_sync      = hs_q;
    assign bus.out_v_sync      = vs_q;
    assign bus.out_row         = row_q;
    assign bus.out_row_pixel   = rpix_q;
    assign bus.out_col         = col_q;
    assign bus.out_col_valid   = cvld_q;
    assign bus.out_col_start   = cstart_q;
    assign bus.out_col_pixel   = cpix_q;
    assign bus.out_cursor      = cursor_q;
    assign bus.out_blink       = blink_q;
    assign bus.out_frame_start = fstart_q;
endmodule

// File: tb/tb_hdmi_text_grid.sv
// Purpose: directed self-checking bench for hdmi_text_grid (rows, wrap, columns, double height, cursor/blink, async reset).
// Latency: expects all outputs one clock after the driving inputs.
// Backpressure: none exercised; the stream is free-running.
module tb_hdmi_text_grid;
    localparam int CELL_W = 10;
    localparam int CELL_H = 20;
    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int BF     = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   compared = 0;
    int   failed   = 0;

    hdmi_text_grid_if #(.CELL_W(CELL_W), .CELL_H(CELL_H), .COLS(COLS), .ROWS(ROWS)) bus ();

    hdmi_text_grid #(
        .CELL_W(CELL_W), .CELL_H(CELL_H), .COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BF)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // one pixel clock: drive, let the edge register it, settle 1 time unit
    task automatic cyc(input logic act, input logic hs, input logic vs,
                       input logic hst, input logic vst);
        bus.in_active  = act;
        bus.in_h_sync  = hs;
        bus.in_v_sync  = vs;
        bus.in_h_start = hst;
        bus.in_v_start = vst;
        @(posedge clk);
        #1;
    endtask

    // one short active line plus blanking; returns the row state seen on its first pixel
    task automatic run_line(input logic vst, input int npix,
                            output logic [4:0] r0, output logic [4:0] p0, output logic fs0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, vst);
        r0  = bus.out_row;
        p0  = bus.out_row_pixel;
        fs0 = bus.out_frame_start;
        for (int i = 1; i < npix; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        logic [39:0] outs;
        bus.top_row = '0; bus.fine_scroll = '0; bus.double_height = 1'b0;
        bus.cursor_enable = 1'b0; bus.cursor_row = '0; bus.cursor_col = '0;
        reset_n = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        outs = 40'({bus.out_active, bus.out_h_sync, bus.out_v_sync, bus.out_row, bus.out_row_pixel,
                    bus.out_col, bus.out_col_valid, bus.out_col_start, bus.out_col_pixel,
                    bus.out_cursor, bus.out_frame_start});
        compared++;
        if (outs !== 40'd0) begin failed++; $display("FAIL reset_outs: got %h expected 0", outs); end
        compared++;
        if (bus.out_blink !== 1'b1) begin failed++; $display("FAIL reset_blink: got %b expected 1", bus.out_blink); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_rows;
        logic [4:0] r, p;
        logic fs;
        bus.top_row = 5'd5; bus.fine_scroll = 5'd0; bus.double_height = 1'b0;
        run_line(1'b1, 4, r, p, fs);
        compared++;
        if (r !== 5'd5 || p !== 5'd0 || fs !== 1'b1) begin
            failed++; $display("FAIL rows_first: row=%0d pix=%0d fs=%b expected 5 0 1", r, p, fs);
        end
        compared++;
        if (bus.out_frame_start !== 1'b0) begin failed++; $display("FAIL rows_fs_pulse: got %b expected 0", bus.out_frame_start); end
        for (int n = 1; n <= 20; n++) begin
            if (n == 5) bus.top_row = 5'd12;
            run_line(1'b0, 4, r, p, fs);
            if (n == 19) begin
                compared++;
                if (r !== 5'd5 || p !== 5'd19) begin failed++; $display("FAIL rows_l19: row=%0d pix=%0d expected 5 19", r, p); end
            end
            if (n == 20) begin
                compared++;
                if (r !== 5'd6 || p !== 5'd0) begin failed++; $display("FAIL rows_l20: row=%0d pix=%0d expected 6 0", r, p); end
            end
        end
    endtask

    task automatic test_wrap;
        logic [4:0] r, p;
        logic fs;
        bus.top_row = 5'd29; bus.fine_scroll = 5'd0;
        run_line(1'b1, 4, r, p, fs);
        for (int n = 1; n <= 20; n++) run_line(1'b0, 4, r, p, fs);
        compared++;
        if (r !== 5'd0 || p !== 5'd0) begin failed++; $display("FAIL wrap_row: row=%0d pix=%0d expected 0 0", r, p); end
        bus.fine_scroll = 5'd25;
        run_line(1'b1, 4, r, p, fs);
        compared++;
        if (r !== 5'd29 || p !== 5'd19) begin failed++; $display("FAIL wrap_clamp: row=%0d pix=%0d expected 29 19", r, p); end
        run_line(1'b0, 4, r, p, fs);
        compared++;
        if (r !== 5'd0 || p !== 5'd0) begin failed++; $display("FAIL wrap_after_clamp: row=%0d pix=%0d expected 0 0", r, p); end
        bus.fine_scroll = 5'd0;
    endtask

    task automatic test_columns;
        int ecol;
        bus.top_row = 5'd0;
        for (int i = 0; i < 810; i++) begin
            cyc(1'b1, 1'b0, 1'b0, i == 0, i == 0);
            ecol = i / 10;
            compared++;
            if (bus.out_col !== 7'(ecol) || bus.out_col_pixel !== 4'(i % 10)) begin
                failed++; $display("FAIL col_pos@%0d: col=%0d pix=%0d expected %0d %0d", i, bus.out_col, bus.out_col_pixel, ecol, i % 10);
            end
            compared++;
            if (bus.out_col_start !== (i % 10 == 0) || bus.out_col_valid !== (i < 800) || bus.out_active !== 1'b1) begin
                failed++; $display("FAIL col_flags@%0d: start=%b valid=%b act=%b", i, bus.out_col_start, bus.out_col_valid, bus.out_active);
            end
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        compared++;
        if ({bus.out_active, bus.out_col, bus.out_col_pixel, bus.out_col_start, bus.out_col_valid} !== 14'd0 ||
            bus.out_h_sync !== 1'b1 || bus.out_v_sync !== 1'b1) begin
            failed++; $display("FAIL col_blank: act=%b col=%0d pix=%0d hs=%b vs=%b expected 0 0 0 1 1",
                               bus.out_active, bus.out_col, bus.out_col_pixel, bus.out_h_sync, bus.out_v_sync);
        end
        // line start on the same pixel that would wrap the cell
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        compared++;
        if (bus.out_col !== 7'd0 || bus.out_col_pixel !== 4'd0 || bus.out_col_start !== 1'b1) begin
            failed++; $display("FAIL col_hstart_wins: col=%0d pix=%0d start=%b expected 0 0 1", bus.out_col, bus.out_col_pixel, bus.out_col_start);
        end
        // v_start without h_start is not a frame start
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        compared++;
        if (bus.out_frame_start !== 1'b0 || bus.out_col_pixel !== 4'd1) begin
            failed++; $display("FAIL col_vstart_only: fs=%b pix=%0d expected 0 1", bus.out_frame_start, bus.out_col_pixel);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // long line saturates the column counter
        for (int i = 0; i < 1300; i++) cyc(1'b1, 1'b0, 1'b0, i == 0, 1'b0);
        compared++;
        if (bus.out_col !== 7'd127 || bus.out_col_valid !== 1'b0) begin
            failed++; $display("FAIL col_saturate: col=%0d valid=%b expected 127 0", bus.out_col, bus.out_col_valid);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_double_height;
        logic [4:0] r, p;
        logic fs;
        bus.top_row = 5'd5; bus.fine_scroll = 5'd0; bus.double_height = 1'b1;
        run_line(1'b1, 4, r, p, fs);
        compared++;
        if (r !== 5'd5 || p !== 5'd0) begin failed++; $display("FAIL dh_first: row=%0d pix=%0d expected 5 0", r, p); end
        for (int n = 1; n <= 41; n++) begin
            if (n == 10) begin bus.double_height = 1'b0; bus.top_row = 5'd0; end
            run_line(1'b0, 4, r, p, fs);
            compared++;
            if (r !== 5'(5 + n / 40) || p !== 5'((n / 2) % 20)) begin
                failed++; $display("FAIL dh_line%0d: row=%0d pix=%0d expected %0d %0d", n, r, p, 5 + n / 40, (n / 2) % 20);
            end
        end
        run_line(1'b1, 4, r, p, fs);
        run_line(1'b0, 4, r, p, fs);
        compared++;
        if (r !== 5'd0 || p !== 5'd1) begin failed++; $display("FAIL dh_next_frame: row=%0d pix=%0d expected 0 1", r, p); end
        bus.double_height = 1'b1;
        run_line(1'b0, 4, r, p, fs);
        compared++;
        if (p !== 5'd2) begin failed++; $display("FAIL dh_midframe_on: pix=%0d expected 2", p); end
        bus.double_height = 1'b0;
    endtask

    task automatic test_cursor_blink;
        logic exp_blink, exp_cur;
        reset_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        bus.top_row = 5'd5; bus.fine_scroll = 5'd0; bus.double_height = 1'b0;
        bus.cursor_row = 5'd5; bus.cursor_col = 7'd3;
        // blink on for frames 1, 4, 5 and off for 2, 3 with two frames per half-period
        for (int f = 1; f <= 5; f++) begin
            exp_blink = (f == 1 || f == 4 || f == 5);
            bus.cursor_enable = (f != 5);
            for (int ln = 0; ln < 22; ln++) begin
                for (int px = 0; px < 50; px++) begin
                    cyc(1'b1, 1'b0, 1'b0, px == 0, px == 0 && ln == 0);
                    if (px == 0 && ln == 0) begin
                        compared++;
                        if (bus.out_blink !== exp_blink || bus.out_row !== 5'd5) begin
                            failed++; $display("FAIL blink_f%0d: blink=%b row=%0d expected %b 5", f, bus.out_blink, bus.out_row, exp_blink);
                        end
                    end
                    exp_cur = (f != 5) && exp_blink && ln < 20 && px >= 30 && px <= 39;
                    compared++;
                    if (bus.out_cursor !== exp_cur) begin
                        failed++; $display("FAIL cursor_f%0d_l%0d_p%0d: got %b expected %b", f, ln, px, bus.out_cursor, exp_cur);
                    end
                end
                cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [39:0] outs;
        logic [4:0] r, p;
        logic fs;
        bus.cursor_enable = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i < 35; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        compared++;
        if (bus.out_blink !== 1'b0 || bus.out_col !== 7'd3) begin
            failed++; $display("FAIL areset_pre: blink=%b col=%0d expected 0 3", bus.out_blink, bus.out_col);
        end
        #2;
        reset_n = 1'b0;
        #1;
        outs = 40'({bus.out_active, bus.out_h_sync, bus.out_v_sync, bus.out_row, bus.out_row_pixel,
                    bus.out_col, bus.out_col_valid, bus.out_col_start, bus.out_col_pixel,
                    bus.out_cursor, bus.out_frame_start});
        compared++;
        if (outs !== 40'd0 || bus.out_blink !== 1'b1) begin
            failed++; $display("FAIL areset_outs: outs=%h blink=%b expected 0 1", outs, bus.out_blink);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.top_row = 5'd7;
        run_line(1'b1, 4, r, p, fs);
        compared++;
        if (r !== 5'd7 || p !== 5'd0 || fs !== 1'b1) begin
            failed++; $display("FAIL areset_resume: row=%0d pix=%0d fs=%b expected 7 0 1", r, p, fs);
        end
        run_line(1'b0, 4, r, p, fs);
        compared++;
        if (r !== 5'd7 || p !== 5'd1 || bus.out_blink !== 1'b1) begin
            failed++; $display("FAIL areset_count: row=%0d pix=%0d blink=%b expected 7 1 1", r, p, bus.out_blink);
        end
    endtask

    initial begin
        bus.in_active = 1'b0; bus.in_h_sync = 1'b0; bus.in_v_sync = 1'b0;
        bus.in_h_start = 1'b0; bus.in_v_start = 1'b0;
        test_reset();
        test_rows();
        test_wrap();
        test_columns();
        test_double_height();
        test_cursor_blink();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
